// File: rtl/mosaic_fu_pkg.sv
// Shared constants for the Mosaic functional unit blocks.
package mosaic_fu_pkg;

    localparam int   FU_W        = 32;
    localparam int   FU_CW       = 5;
    localparam logic NORM_SIGNED = 1'b1;

endpackage

// File: rtl/lead_count.sv
// Combinational leading-zero counter built as a log tree of (all_zero, count) nodes.
module lead_count
    import mosaic_fu_pkg::*;
#(
    parameter int W  = FU_W,
    parameter int CW = FU_CW
) (
    input  logic [W-1:0]  a,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    genvar gl, gi;

    // Node j at level l covers bits [j*2^l +: 2^l]; child 2j+1 is the upper half.
    // An all-zero input saturates the count at W-1 because every node takes the upper-zero path.
    for (gl = 1; gl <= CW; gl++) begin : lvl
        localparam int N = W >> gl;
        logic [N-1:0]  z;
        logic [gl-1:0] c [N];

        for (gi = 0; gi < N; gi++) begin : node
            if (gl == 1) begin : g_leaf
                assign z[gi] = ~a[2*gi+1] & ~a[2*gi];
                assign c[gi] = ~a[2*gi+1];
            end else begin : g_merge
                assign z[gi] = lvl[gl-1].z[2*gi+1] & lvl[gl-1].z[2*gi];
                assign c[gi] = lvl[gl-1].z[2*gi+1] ? {1'b1, lvl[gl-1].c[2*gi]}
                                                   : {1'b0, lvl[gl-1].c[2*gi+1]};
            end
        end
    end

    assign count    = lvl[CW].c[0];
    assign all_zero = lvl[CW].z[0];

endmodule

// File: rtl/norm_shift_unit.sv
// Two-stage elastic normalizer: counts redundant leading bits of X and left-shifts them out.
module norm_shift_unit
    import mosaic_fu_pkg::*;
#(
    parameter int W  = FU_W,
    parameter int CW = FU_CW
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  X,
    input  logic          SIGNED,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [W-1:0]  Z,
    output logic [CW-1:0] CNT,
    output logic          ZERO
);

    logic          s1_v_q, s1_v_d;
    logic          signed_q, signed_d;
    logic [W-1:0]  x_q, x_d;
    logic          s2_v_q, s2_v_d;
    logic [W-1:0]  z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;

    logic          s1_adv, s2_adv;
    logic [W-1:0]  lc_in;
    logic [CW-1:0] lc_cnt;
    logic          lc_zero;
    logic [W-1:0]  sh [CW+1];

    assign s2_adv   = !s2_v_q || OUT_READY;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign IN_READY = s1_adv;

    // Adjacent-bit XOR marks where the sign run ends, so sign counting becomes zero counting.
    assign lc_in = (signed_q == NORM_SIGNED) ? {x_q[W-1:1] ^ x_q[W-2:0], 1'b0} : x_q;

    lead_count #(
        .W  (W),
        .CW (CW)
    ) u_lead_count (
        .a        (lc_in),
        .count    (lc_cnt),
        .all_zero (lc_zero)
    );

    genvar gi;

    assign sh[0] = x_q;
    for (gi = 0; gi < CW; gi++) begin : g_shift
        localparam int AMT = 1 << (CW - 1 - gi);
        assign sh[gi+1] = lc_cnt[CW-1-gi] ? (sh[gi] << AMT) : sh[gi];
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        x_d      = x_q;
        signed_d = signed_q;
        s2_v_d   = s2_v_q;
        z_d      = z_q;
        cnt_d    = cnt_q;
        zero_d   = zero_q;

        if (s1_adv) begin
            s1_v_d = IN_VALID;
            if (IN_VALID) begin
                x_d      = X;
                signed_d = SIGNED;
            end
        end

        // Result registers only change when a new operand moves in, keeping them stable under stall.
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                z_d    = sh[CW];
                cnt_d  = lc_cnt;
                zero_d = lc_zero;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s1_v_q   <= 1'b0;
            x_q      <= '0;
            signed_q <= 1'b0;
            s2_v_q   <= 1'b0;
            z_q      <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            x_q      <= x_d;
            signed_q <= signed_d;
            s2_v_q   <= s2_v_d;
            z_q      <= z_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
        end
    end

    assign OUT_VALID = s2_v_q;
    assign Z         = z_q;
    assign CNT       = cnt_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_norm_shift_unit.sv
// Randomized self-checking bench for norm_shift_unit against a bit-scanning reference model.
module tb_norm_shift_unit;

    logic        clk = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] X;
    logic        SIGNED;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] Z;
    logic [4:0]  CNT;
    logic        ZERO;

    always #5 clk = ~clk;

    norm_shift_unit dut (
        .CLOCK     (clk),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .X         (X),
        .SIGNED    (SIGNED),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Z         (Z),
        .CNT       (CNT),
        .ZERO      (ZERO)
    );

    typedef struct packed {
        logic        zero;
        logic [4:0]  cnt;
        logic [31:0] z;
    } res_t;

    int   vectors     = 0;
    int   miscompares = 0;
    res_t exp_q[$];

    // Scan from the MSB counting bits equal to the lead value, then apply the mode rules.
    function automatic res_t ref_norm(input logic [31:0] x, input logic sg);
        res_t r;
        int   n;
        logic lead;
        lead = sg ? x[31] : 1'b0;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (x[i] != lead) break;
            n++;
        end
        r.zero = (n == 32);
        if (sg) r.cnt = 5'(n - 1);
        else    r.cnt = (n == 32) ? 5'd31 : 5'(n);
        r.z = x << r.cnt;
        return r;
    endfunction

    function automatic logic [31:0] rand_operand(input logic sg);
        logic [31:0] x;
        x = $urandom >> $urandom_range(0, 31);
        if (sg && ($urandom_range(0, 1) == 1)) x = ~x;
        if ($urandom_range(0, 15) == 0) x = sg ? 32'hFFFF_FFFF : 32'h0;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b1; X = 32'h0001_0000; SIGNED = 1'b0; OUT_READY = 1'b1;
        tick();
        RESET = 1'b0; IN_VALID = 1'b0;
        #1;
        vectors++;
        if ({OUT_VALID, Z, CNT, ZERO, IN_READY} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b z=%h cnt=%0d zero=%b rdy=%b, want 0 00000000 0 0 1",
                     OUT_VALID, Z, CNT, ZERO, IN_READY);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (OUT_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_accept: got out_valid=%b, want 0 (cycle %0d)", OUT_VALID, c);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] tx [10] = '{32'h0001_0000, 32'hFFFF_8000, 32'h4000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                                 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        logic        ts [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] tz [10] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000,
                                 32'h0000_0000, 32'h8000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [4:0]  tc [10] = '{5'd15, 5'd16, 5'd0, 5'd31, 5'd31, 5'd31, 5'd0, 5'd30, 5'd0, 5'd31};
        logic        tzr[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int k = 0; k < 10; k++) begin
            IN_VALID = 1'b1; X = tx[k]; SIGNED = ts[k]; OUT_READY = 1'b1;
            #1;
            vectors++;
            if (IN_READY !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_in_ready[%0d]: got %b, want 1", k, IN_READY);
            end
            tick();
            IN_VALID = 1'b0;
            lat = 1;
            while (!OUT_VALID && lat < 8) begin
                tick();
                lat++;
            end
            vectors++;
            if (!OUT_VALID || lat != 2) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got valid=%b after %0d cycles, want valid=1 after 2", k, OUT_VALID, lat);
            end
            vectors++;
            if ({Z, CNT, ZERO} !== {tz[k], tc[k], tzr[k]}) begin
                miscompares++;
                $display("FAIL directed[%0d]: x=%h s=%b got z=%h cnt=%0d zero=%b, want z=%h cnt=%0d zero=%b",
                         k, tx[k], ts[k], Z, CNT, ZERO, tz[k], tc[k], tzr[k]);
            end
            $display("txn directed x=%h s=%b -> z=%h cnt=%0d zero=%b", tx[k], ts[k], Z, CNT, ZERO);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [8];
        logic        sg  [8];
        res_t        r;
        int in_i = 0, out_i = 0, first = -1, last = -1, cyc = 0;
        for (int i = 0; i < 8; i++) begin
            sg[i]  = 1'($urandom_range(0, 1));
            ops[i] = rand_operand(sg[i]);
        end
        OUT_READY = 1'b1;
        while (out_i < 8 && cyc < 40) begin
            IN_VALID = (in_i < 8);
            if (in_i < 8) begin X = ops[in_i]; SIGNED = sg[in_i]; end
            #1;
            if (OUT_VALID) begin
                r = ref_norm(ops[out_i], sg[out_i]);
                vectors++;
                if ({Z, CNT, ZERO} !== {r.z, r.cnt, r.zero}) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: x=%h s=%b got z=%h cnt=%0d zero=%b, want z=%h cnt=%0d zero=%b",
                             out_i, ops[out_i], sg[out_i], Z, CNT, ZERO, r.z, r.cnt, r.zero);
                end
                $display("txn b2b x=%h s=%b -> z=%h cnt=%0d zero=%b", ops[out_i], sg[out_i], Z, CNT, ZERO);
                if (first < 0) first = cyc;
                last = cyc;
                out_i++;
            end
            if (IN_VALID && IN_READY) in_i++;
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        vectors++;
        if (out_i != 8 || last - first != 7) begin
            miscompares++;
            $display("FAIL b2b_stream: got %0d results over %0d cycles, want 8 over 8", out_i, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        res_t r;
        int   accepts = 0, got = 0;
        exp_q.delete();
        OUT_READY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1; SIGNED = 1'($urandom_range(0, 1)); X = rand_operand(SIGNED);
            #1;
            if (c >= 2) begin
                vectors++;
                if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || exp_q.size() == 0 ||
                    {Z, CNT, ZERO} !== {exp_q[0].z, exp_q[0].cnt, exp_q[0].zero}) begin
                    miscompares++;
                    $display("FAIL bp_stall[%0d]: got rdy=%b valid=%b z=%h cnt=%0d, want rdy=0 valid=1 stable head",
                             c, IN_READY, OUT_VALID, Z, CNT);
                end
            end
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(ref_norm(X, SIGNED));
                accepts++;
            end
            tick();
        end
        vectors++;
        if (accepts != 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d, want 2", accepts);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (OUT_VALID) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_extra: got z=%h cnt=%0d, want no result", Z, CNT);
                end else begin
                    r = exp_q.pop_front();
                    if ({Z, CNT, ZERO} !== {r.z, r.cnt, r.zero}) begin
                        miscompares++;
                        $display("FAIL bp_drain[%0d]: got z=%h cnt=%0d zero=%b, want z=%h cnt=%0d zero=%b",
                                 got, Z, CNT, ZERO, r.z, r.cnt, r.zero);
                    end
                end
                $display("txn backpressure -> z=%h cnt=%0d zero=%b", Z, CNT, ZERO);
                got++;
            end
            tick();
        end
        vectors++;
        if (got != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_release: got %0d results, want 2", got);
        end
    endtask

    task automatic test_random_stall();
        res_t        r;
        logic        stalled_prev = 1'b0;
        logic [37:0] snap = '0;
        int sent = 0, received = 0, cyc = 0;
        exp_q.delete();
        while (received < 40 && cyc < 600) begin
            IN_VALID  = (sent < 40) && ($urandom_range(0, 3) != 0);
            SIGNED    = 1'($urandom_range(0, 1));
            X         = rand_operand(SIGNED);
            OUT_READY = ($urandom_range(0, 4) < 3);
            #1;
            vectors++;
            if (IN_READY !== ((exp_q.size() < 2) || OUT_READY)) begin
                miscompares++;
                $display("FAIL rs_in_ready: got %b with %0d in flight, out_ready=%b", IN_READY, exp_q.size(), OUT_READY);
            end
            if (stalled_prev) begin
                vectors++;
                if ({OUT_VALID, Z, CNT, ZERO} !== {1'b1, snap}) begin
                    miscompares++;
                    $display("FAIL rs_hold: got valid=%b z=%h cnt=%0d zero=%b, want held z=%h cnt=%0d zero=%b",
                             OUT_VALID, Z, CNT, ZERO, snap[37:6], snap[5:1], snap[0]);
                end
            end
            if (OUT_VALID && OUT_READY) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rs_extra: got z=%h cnt=%0d, want no result", Z, CNT);
                end else begin
                    r = exp_q.pop_front();
                    if ({Z, CNT, ZERO} !== {r.z, r.cnt, r.zero}) begin
                        miscompares++;
                        $display("FAIL rs_result[%0d]: got z=%h cnt=%0d zero=%b, want z=%h cnt=%0d zero=%b",
                                 received, Z, CNT, ZERO, r.z, r.cnt, r.zero);
                    end
                end
                $display("txn random -> z=%h cnt=%0d zero=%b", Z, CNT, ZERO);
                received++;
            end
            stalled_prev = OUT_VALID && !OUT_READY;
            snap = {Z, CNT, ZERO};
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(ref_norm(X, SIGNED));
                sent++;
            end
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        vectors++;
        if (received != 40) begin
            miscompares++;
            $display("FAIL rs_count: got %0d results, want 40", received);
        end
    endtask

    task automatic test_reset_midflight();
        OUT_READY = 1'b0;
        for (int c = 0; c < 2; c++) begin
            IN_VALID = 1'b1; SIGNED = 1'b0; X = 32'h0000_0F00 + 32'(c);
            tick();
        end
        vectors++;
        if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_fill: got valid=%b rdy=%b, want valid=1 rdy=0", OUT_VALID, IN_READY);
        end
        RESET = 1'b1; IN_VALID = 1'b1; X = 32'h0000_1234;
        tick();
        RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
        #1;
        vectors++;
        if ({OUT_VALID, Z, CNT, ZERO, IN_READY} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b z=%h cnt=%0d zero=%b rdy=%b, want 0 00000000 0 0 1",
                     OUT_VALID, Z, CNT, ZERO, IN_READY);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (OUT_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_flush[%0d]: got out_valid=%b z=%h, want 0", c, OUT_VALID, Z);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        RESET = 1'b1; IN_VALID = 1'b0; X = '0; SIGNED = 1'b0; OUT_READY = 1'b0;
        tick();
        tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_stall();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/norm_shift_unit.md
Name: norm_shift_unit

Overview:
Normalizer for the Mosaic functional unit, and the inverse of the bi-directional shifter: the shifter applies a given shift amount, and this block derives one. It takes a 32-bit operand, counts its redundant leading bits (leading zeros, or redundant sign bits), left-shifts the operand to normalize it, and returns both the normalized value and the shift count. It is a 2-stage elastic pipeline with valid/ready handshakes on both sides, so it can sit between the operand crossbar and the result bus.

Parameters:
W, 32, datapath width; must be a power of two.
CW, 5, count width; equals log2(W).

Ports:
CLOCK  in  1  single clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
IN_VALID  in  1  input operand valid
IN_READY  out  1  block can accept an operand this cycle
X  in  W  operand
SIGNED  in  1  1 = count redundant sign bits; 0 = count leading zeros
OUT_VALID  out  1  result valid
OUT_READY  in  1  downstream accepts the result this cycle
Z  out  W  normalized operand
CNT  out  CW  applied left-shift amount
ZERO  out  1  operand has no significant bits (X=0, or X=all-ones in signed mode)

Behaviour:
- Input accept when IN_VALID & IN_READY. Output transfer when OUT_VALID & OUT_READY.
- Stage 1 (S1) registers X, SIGNED and s1_v. Combinational count logic runs on the S1 contents.
- Stage 2 (S2) registers Z, CNT, ZERO and s2_v. Outputs are driven directly from S2 flops.
- Advance rules:
  - s2_adv = !s2_v | OUT_READY
  - s1_adv = !s1_v | s2_adv
  - IN_READY = s1_adv (combinational; no path from IN_VALID to IN_READY)
- S2 loads when s1_v & s2_adv. s2_v clears when the output transfers and s1_v is 0.
- Latency: 2 cycles from accept to OUT_VALID when no stall. Throughput: 1 operand per cycle.
- Stall: S1/S2 contents and Z/CNT/ZERO hold stable while OUT_VALID & !OUT_READY; no operand is lost or duplicated.
- Unsigned mode (SIGNED=0):
  - CNT = number of leading zeros of X
  - Z = X << CNT
  - X=0 gives CNT=31, Z=0, ZERO=1
- Signed mode (SIGNED=1):
  - CNT = (number of leading bits equal to X[31]) - 1
  - Z = X << CNT, so that Z[31] != Z[30]
  - X=0 gives CNT=31, Z=0, ZERO=1
  - X=0xFFFFFFFF gives CNT=31, Z=0x80000000, ZERO=1
- Values with no redundant bits give CNT=0 and Z=X:
  - unsigned X[31]=1
  - signed X[31]!=X[30]
- Shift fills zeros from the LSB. CNT never exceeds W-1. ZERO=0 in all non-degenerate cases.
- Reset (synchronous, active-high): s1_v=0, s2_v=0, OUT_VALID=0, Z=0, CNT=0, ZERO=0. IN_READY reads 1 in the cycle after reset deasserts.
- Reset mid-operation: in-flight operands are discarded. An IN_VALID present in the same cycle as RESET is not accepted.
- Simultaneous accept and transfer in one cycle with a full pipe is legal and keeps full throughput.

Decomposition:
- Shared package mosaic_fu_pkg:
  - FU_W=32
  - FU_CW=5
  - mode encoding constant NORM_SIGNED=1'b1
- Sub-module lead_count: combinational leading-zero counter over W bits, built as a log tree; also outputs all_zero.
  - Signed mode feeds it X ^ {X[W-2:0],1'b0}'s upper W-1 bits (XOR of adjacent bits), which turns sign-bit counting into zero counting.
- The left shift is a 5-stage log barrel (16/8/4/2/1), mirroring the functional-unit shifter structure, and is instantiated inline.

Test Plan:
- Unsigned, X=0x00010000, OUT_READY=1 -> after 2 cycles: OUT_VALID=1, Z=0x80000000, CNT=15, ZERO=0.
- Signed, X=0xFFFF8000 -> Z=0x80000000, CNT=16. Signed, X=0x40000000 -> CNT=0, Z=0x40000000.
- Degenerate inputs:
  - unsigned X=0 -> Z=0, CNT=31, ZERO=1
  - signed X=0xFFFFFFFF -> Z=0x80000000, CNT=31, ZERO=1
- Back-to-back stream of 8 random operands with OUT_READY=1 -> 8 results in 8 consecutive cycles, in order, each matching a reference model.
- Backpressure:
  - OUT_READY held 0 for 5 cycles while IN_VALID=1 -> IN_READY drops after 2 accepts; Z/CNT stay stable.
  - On release -> both results emerge in order with no loss.
- Assert RESET while both stages are valid -> next cycle OUT_VALID=0, CNT=0, Z=0, IN_READY=1; the prior operands never appear on the output.
